// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling 8N1 UART receiver with majority-vote bit decisions
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   rxd            raw serial input, idle high, LSB first
//   rxd_data_ready one-cycle strobe when a valid byte is latched
//   rxd_data       last valid byte, held until the next one
//   frame_err      one-cycle strobe when the stop bit samples low
//   rxd_idle       high while the receiver is waiting for a start edge
module uart_rx_os #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       rxd_data_ready,
    output logic [7:0] rxd_data,
    output logic       frame_err,
    output logic       rxd_idle
);
    localparam int DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int TW  = $clog2(DIV + 1);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam logic [TW-1:0] RELOAD  = TW'(DIV - 1);
    localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SC_A    = SW'(M - 1);
    localparam logic [SW-1:0] SC_B    = SW'(M);
    localparam logic [SW-1:0] SC_C    = SW'(M + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sync_q;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sc_q, sc_d, sn;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d, data_q, data_d;
    logic [1:0]    smp_q, smp_d;
    logic          rdy_q, rdy_d, ferr_q, ferr_d;
    logic          rs, fall, tick, maj, mid, wrap;

    // sync_q[1] is the synchronised line; sync_q[2] is its previous value for edge detection
    assign rs   = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];
    assign tick = cnt_q == '0;
    // sn is the sample index this tick lands on, so samples straddle the bit centre
    assign sn   = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
    assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rs) | (smp_q[1] & rs);
    assign mid  = tick && sn == SC_C;
    assign wrap = tick && sc_q == SC_LAST;

    always_comb begin
        state_d = state_q;
        cnt_d   = (tick || (state_q == IDLE && fall)) ? RELOAD : cnt_q - 1'b1;
        sc_d    = tick ? sn : sc_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        smp_d   = smp_q;
        data_d  = data_q;
        rdy_d   = 1'b0;
        ferr_d  = 1'b0;
        if (tick && sn == SC_A) smp_d[0] = rs;
        if (tick && sn == SC_B) smp_d[1] = rs;
        case (state_q)
            IDLE: begin
                sc_d  = '0;
                idx_d = '0;
                if (fall) state_d = START;
            end
            START: begin
                if (mid && maj) state_d = IDLE;
                else if (wrap) state_d = DATA;
            end
            DATA: begin
                if (mid) sh_d[idx_q] = maj;
                if (wrap) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (mid) begin
                    if (maj) begin
                        data_d  = sh_q;
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        sc_d    = '0;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                // sc counts consecutive high ticks; any low tick restarts the bit period
                sc_d = tick ? (rs ? sn : '0) : sc_q;
                if (tick && rs && sc_q == SC_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 3'b111;
            state_q <= IDLE;
            cnt_q   <= '0;
            sc_q    <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            smp_q   <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rxd};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sc_q    <= sc_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            smp_q   <= smp_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rxd_data_ready = rdy_q;
    assign rxd_data       = data_q;
    assign frame_err      = ferr_q;
    assign rxd_idle       = state_q == IDLE;
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: self-checking bench for uart_rx_os (table, directed and random frames)
// Ports: none; drives clk, rst, rxd and observes all DUT outputs
module tb_uart_rx_os;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rxd_data_ready, frame_err, rxd_idle;
    logic [7:0] rxd_data;

    uart_rx_os #(.CLK_HZ(640000), .BAUD(10000), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .rxd(rxd),
        .rxd_data_ready(rxd_data_ready), .rxd_data(rxd_data),
        .frame_err(frame_err), .rxd_idle(rxd_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         t;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         g;
        int         rdy;
        int         err;
    } vec_t;

    int         tests = 0, fails = 0, cyc = 0;
    int         rdy_cnt = 0, err_cnt = 0, last_rdy = 0, prev_rdy = 0;
    exp_t       sbq[$];
    logic [7:0] prev_data = 8'h00;
    logic [7:0] model_data = 8'h00;
    vec_t       tbl[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (rxd_data_ready || frame_err) check("ready_err_exclusive", int'(rxd_data_ready & frame_err), 0);
            if (rxd_data !== prev_data) check("data_changes_only_with_ready", int'(rxd_data_ready), 1);
            if (rxd_data_ready) begin
                rdy_cnt++;
                prev_rdy = last_rdy;
                last_rdy = cyc;
                if (sbq.size() == 0) check("unexpected_ready", 1, 0);
                else begin
                    e = sbq.pop_front();
                    check("rx_data", int'(rxd_data), int'(e.d));
                    check("latency_in_window", int'((cyc - e.t) >= 605 && (cyc - e.t) <= 625), 1);
                end
            end
            if (frame_err) err_cnt++;
        end
        prev_data = rxd_data;
    end

    task automatic send_bit(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int g, input logic ok);
        exp_t e;
        if (ok) begin
            e.d = d;
            e.t = cyc;
            sbq.push_back(e);
            model_data = d;
        end
        send_bit(1'b0, 64);
        for (int i = 0; i < 8; i++) begin
            if (i == g) begin
                send_bit(d[i], 30);
                send_bit(~d[i], 4);
                send_bit(d[i], 30);
            end else send_bit(d[i], 64);
        end
        send_bit(stop, 64);
    endtask

    initial begin : wd
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int rc, ec, gap, er, ee;
        logic [7:0] d;
        logic st;
        tbl[0] = '{8'hA5, 1'b1, 2, 1, 0};
        tbl[1] = '{8'h5A, 1'b1, 7, 1, 0};
        tbl[2] = '{8'hFF, 1'b1, -1, 1, 0};
        tbl[3] = '{8'h00, 1'b1, -1, 1, 0};
        tbl[4] = '{8'h3C, 1'b0, -1, 0, 1};
        tbl[5] = '{8'h81, 1'b1, 0, 1, 0};

        repeat (3) @(negedge clk);
        check("rst_data", int'(rxd_data), 0);
        check("rst_ready", int'(rxd_data_ready), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_idle", int'(rxd_idle), 1);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_idle", int'(rxd_idle), 1);

        rc = rdy_cnt; ec = err_cnt;
        send_frame(8'h03, 1'b1, -1, 1'b1);
        send_bit(1'b1, 64);
        check("f03_ready_count", rdy_cnt - rc, 1);
        check("f03_err_count", err_cnt - ec, 0);
        check("f03_data", int'(rxd_data), 8'h03);
        check("f03_idle", int'(rxd_idle), 1);

        rc = rdy_cnt; ec = err_cnt;
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        check("glitch_busy", int'(rxd_idle), 0);
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (36) @(negedge clk);
        check("glitch_back_idle", int'(rxd_idle), 1);
        send_bit(1'b1, 64);
        check("glitch_ready_count", rdy_cnt - rc, 0);
        check("glitch_err_count", err_cnt - ec, 0);
        send_frame(8'h10, 1'b1, -1, 1'b1);
        send_bit(1'b1, 64);
        check("after_glitch_ready_count", rdy_cnt - rc, 1);
        check("after_glitch_data", int'(rxd_data), 8'h10);

        send_frame(8'h03, 1'b1, -1, 1'b1);
        send_bit(1'b1, 64);
        rc = rdy_cnt; ec = err_cnt;
        send_frame(8'h67, 1'b0, -1, 1'b0);
        check("brk_err_count", err_cnt - ec, 1);
        send_bit(1'b0, 320);
        check("brk_hold_busy", int'(rxd_idle), 0);
        check("brk_err_count_hold", err_cnt - ec, 1);
        check("brk_ready_count", rdy_cnt - rc, 0);
        check("brk_data_kept", int'(rxd_data), int'(model_data));
        send_bit(1'b1, 80);
        send_frame(8'h68, 1'b1, -1, 1'b1);
        send_bit(1'b1, 64);
        check("after_brk_ready_count", rdy_cnt - rc, 1);
        check("after_brk_data", int'(rxd_data), 8'h68);

        rc = rdy_cnt;
        send_frame(8'h67, 1'b1, -1, 1'b1);
        check("b2b_first_data", int'(rxd_data), 8'h67);
        send_frame(8'h10, 1'b1, -1, 1'b1);
        send_bit(1'b1, 64);
        check("b2b_ready_count", rdy_cnt - rc, 2);
        check("b2b_gap", last_rdy - prev_rdy, 640);
        check("b2b_second_data", int'(rxd_data), 8'h10);

        for (int i = 0; i < 6; i++) begin
            rc = rdy_cnt; ec = err_cnt;
            send_frame(tbl[i].d, tbl[i].stop, tbl[i].g, tbl[i].rdy[0]);
            send_bit(1'b1, 128);
            check("tbl_ready_count", rdy_cnt - rc, tbl[i].rdy);
            check("tbl_err_count", err_cnt - ec, tbl[i].err);
            check("tbl_data", int'(rxd_data), int'(model_data));
        end

        rc = rdy_cnt; ec = err_cnt;
        send_bit(1'b0, 64);
        send_bit(1'b1, 256);
        send_bit(1'b0, 20);
        rst = 1'b1;
        #1;
        model_data = 8'h00;
        check("midrst_data", int'(rxd_data), 0);
        check("midrst_ready", int'(rxd_data_ready), 0);
        check("midrst_ferr", int'(frame_err), 0);
        check("midrst_idle", int'(rxd_idle), 1);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        send_bit(1'b1, 200);
        check("midrst_no_ready", rdy_cnt - rc, 0);
        check("midrst_no_err", err_cnt - ec, 0);
        send_frame(8'h0F, 1'b1, -1, 1'b1);
        send_bit(1'b1, 64);
        check("midrst_next_ready", rdy_cnt - rc, 1);
        check("midrst_next_data", int'(rxd_data), 8'h0F);

        rc = rdy_cnt; ec = err_cnt; er = 0; ee = 0;
        for (int i = 0; i < 40; i++) begin
            d  = 8'($urandom);
            st = $urandom_range(0, 4) != 0;
            send_frame(d, st, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1, st);
            if (st) er++; else ee++;
            gap = st ? (($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 150)))
                     : int'($urandom_range(80, 200));
            if (gap > 0) send_bit(1'b1, gap);
        end
        send_bit(1'b1, 100);
        check("rand_ready_count", rdy_cnt - rc, er);
        check("rand_err_count", err_cnt - ec, ee);
        check("rand_last_data", int'(rxd_data), int'(model_data));
        check("scoreboard_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver that feeds the robot's command decoder with position codes (1..16) and storage codes (103..113) from the two serial links.
- Synchronises the asynchronous rxd line and detects start bits with majority-vote sampling.
- Delivers each valid byte as a held data word plus a one-cycle ready strobe.
- Flags framing errors, so corrupted bytes never reach the decoder.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit; must be even and at least 8.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rxd  in  1  raw serial input; idle high; 8N1, LSB first.
- rxd_data_ready  out  1  one-cycle pulse when a valid byte has been latched.
- rxd_data  out  8  last valid byte; held until the next valid byte.
- frame_err  out  1  one-cycle pulse when the stop bit samples low.
- rxd_idle  out  1  high while the FSM is in IDLE.

Behaviour:
- Reset values: rxd_data=0x00, rxd_data_ready=0, frame_err=0, rxd_idle=1, FSM=IDLE, all counters 0, synchroniser flops=1.
- Reset asserted mid-frame aborts the frame immediately. No pulse is emitted. After release the receiver waits for a fresh falling edge.
- Synchroniser: 2-flop chain on rxd; all logic uses the synchronised value rs.
- Tick generator: DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), i.e. rounded.
  - Free-running down-counter, reloaded on the falling edge of rs in IDLE so ticks are phase-aligned to the start edge.
  - tick is a one-cycle pulse every DIV clocks.
- Sample counter: sc, 0..OVERSAMPLE-1, increments on tick. Mid-bit decision uses the majority of rs at sc = M-1, M, M+1, where M = OVERSAMPLE/2.
- FSM states and transitions:
  - IDLE: on rs falling edge -> START; clear sc.
  - START: at the majority decision:
    - majority 1 (glitch) -> IDLE, no output.
    - majority 0 -> DATA at sc wrap; bit index 0.
  - DATA: one majority decision per bit, shifted into bit[idx] (LSB first). After idx 7 completes its bit period -> STOP.
  - STOP: at the majority decision:
    - majority 1: rxd_data <= shift register and rxd_data_ready=1, both in the clock after the decision -> IDLE.
    - majority 0: frame_err=1 for one clock; rxd_data unchanged -> BREAK.
  - BREAK: stay until rs has been 1 for one full bit period (OVERSAMPLE consecutive ticks) -> IDLE. Low periods of any length, including a line break, produce no further outputs.
- Latency: ready pulse = start edge at pin + 2 sync clocks + 9.5 bit periods (+/- 1 tick) + 1 clock.
- Back-to-back frames: the FSM returns to IDLE at the stop-bit mid-sample, so a start edge arriving half a bit later is caught. Single stop bit, no gap, is supported.
- rxd_data_ready and frame_err are never high in the same cycle.
- rxd_data never changes except in the cycle rxd_data_ready is asserted.
- Width rules: the tick counter is sized ceil(log2(DIV+1)). sc and idx wrap exactly at their terminal values, with no overflow into the next state.

Test Plan (sim parameters CLK_HZ=640000, BAUD=10000, OVERSAMPLE=16 -> DIV=4, bit = 64 clks):
- Reset, then send 0x03 -> exactly one rxd_data_ready pulse ~610 clks after the start edge; rxd_data=0x03; frame_err stays 0; rxd_idle returns to 1.
- Drive rxd low for 3 ticks (12 clks), then high -> no ready or error pulse; rxd_idle back to 1 within 9 ticks; a following 0x10 is received correctly.
- After 0x03, send 0x67 with stop bit forced 0 and hold low 5 bit times -> one frame_err pulse; rxd_data stays 0x03; no pulse during the low hold; the next 0x68 is received once rxd has been high for 1 bit.
- Send 0x67 then 0x10 back-to-back with one stop bit -> two ready pulses 640 clks apart; rxd_data=0x67, then 0x10.
- Send 0xA5 with a 1-tick low glitch at the mid-sample of bit 2 -> majority vote yields rxd_data=0xA5, one ready pulse.
- Assert rst during bit 4 of 0x0F, release -> outputs at reset values, no pulse; a subsequent 0x0F is received with one ready pulse.
